// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the N-master round-robin bus arbiter.
package bus_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Read data returned on a timed-out access.
    localparam int unsigned ERR_RDATA = 0;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    // Low bit of lane idx in a flat vector of w-bit lanes.
    function automatic int unsigned lane_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/bus_arb_rr_picker.sv
// Rotating-priority encoder: first set request at or after i_start (with wrap),
// skipping requests flagged in i_excl.
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    input  logic [N-1:0]  i_excl,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    int unsigned w_start;
    int unsigned w_dist;
    int unsigned w_best;

    // Pick the eligible requester with the smallest wrapped distance from i_start.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_best  = N;
        w_dist  = 0;
        w_start = {{(32-IW){1'b0}}, i_start};
        for (int unsigned i = 0; i < N; i++) begin
            w_dist = (i + N - w_start) % N;
            if (i_req[i] && !i_excl[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_idx   = IW'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter_n.sv
// Registered-grant N-master round-robin bus arbiter with lock hold and
// per-access timeout that completes a hung transfer with an error.
module bus_rr_arbiter_n
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_wstrb,
    input  logic [NUM_MASTERS-1:0]          m_write,
    input  logic [NUM_MASTERS-1:0]          m_enable,
    input  logic [NUM_MASTERS-1:0]          m_lock,
    output logic [NUM_MASTERS*DATA_W-1:0]   m_rdata,
    output logic [NUM_MASTERS-1:0]          m_ready,
    output logic [NUM_MASTERS-1:0]          m_err,
    output logic [ADDR_W-1:0]               bus_addr,
    output logic [DATA_W-1:0]               bus_wdata,
    output logic [DATA_W/8-1:0]             bus_wstrb,
    output logic                            bus_write,
    output logic                            bus_enable,
    input  logic [DATA_W-1:0]               bus_rdata,
    input  logic                            bus_ready,
    output logic                            grant_valid,
    output logic [clog2(NUM_MASTERS)-1:0]   grant_id
);

    localparam int unsigned IW    = clog2(NUM_MASTERS);
    localparam int unsigned SW    = DATA_W / 8;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0]    LAST_ID = IW'(NUM_MASTERS - 1);

    arb_state_t       r_state, w_state_nx;
    logic [IW-1:0]    r_grant, w_grant_nx;
    logic [IW-1:0]    r_rr_ptr, w_rr_ptr_nx;
    logic [CNT_W-1:0] r_wait, w_wait_nx;

    logic                   w_busy;
    logic                   w_gen;
    logic                   w_timeout;
    logic                   w_done;
    logic [IW-1:0]          w_nxt_id;
    logic [NUM_MASTERS-1:0] w_excl;
    logic                   w_idle_vld, w_ho_vld;
    logic [IW-1:0]          w_idle_idx, w_ho_idx;

    assign w_busy    = (r_state == ST_BUSY);
    assign w_gen     = w_busy && m_enable[r_grant];
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_gen && !bus_ready && (r_wait == TO_LAST);
    assign w_done    = w_gen && (bus_ready || w_timeout);
    assign w_nxt_id  = (r_grant == LAST_ID) ? '0 : r_grant + IW'(1);
    assign w_excl    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << r_grant;

    rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_pick_idle (
        .i_req   (m_enable),
        .i_start (r_rr_ptr),
        .i_excl  ('0),
        .o_valid (w_idle_vld),
        .o_idx   (w_idle_idx)
    );

    // Handoff ignores the finishing master: its enable is still the old request.
    rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_pick_handoff (
        .i_req   (m_enable),
        .i_start (w_nxt_id),
        .i_excl  (w_excl),
        .o_valid (w_ho_vld),
        .o_idx   (w_ho_idx)
    );

    // State, grant, round-robin pointer and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_wait   <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_grant  <= w_grant_nx;
            r_rr_ptr <= w_rr_ptr_nx;
            r_wait   <= w_wait_nx;
        end
    end

    // Next-state decisions plus bus/master lane muxing for the granted master.
    always_comb begin
        w_state_nx  = r_state;
        w_grant_nx  = r_grant;
        w_rr_ptr_nx = r_rr_ptr;
        w_wait_nx   = r_wait;
        bus_addr    = '0;
        bus_wdata   = '0;
        bus_wstrb   = '0;
        bus_write   = 1'b0;
        bus_enable  = 1'b0;
        m_rdata     = '0;
        m_ready     = '0;
        m_err       = '0;
        grant_valid = w_busy;
        grant_id    = w_busy ? r_grant : '0;

        case (r_state)
            ST_IDLE: begin
                if (w_idle_vld) begin
                    w_state_nx = ST_BUSY;
                    w_grant_nx = w_idle_idx;
                    w_wait_nx  = '0;
                end
            end
            ST_BUSY: begin
                if (w_done) begin
                    w_rr_ptr_nx = w_nxt_id;
                    w_wait_nx   = '0;
                    if (!m_lock[r_grant]) begin
                        if (w_ho_vld) w_grant_nx = w_ho_idx;
                        else          w_state_nx = ST_IDLE;
                    end
                end else if (!m_enable[r_grant] && !m_lock[r_grant]) begin
                    w_state_nx = ST_IDLE;
                end else if (w_gen && !bus_ready && (r_wait != CNT_MAX)) begin
                    w_wait_nx = r_wait + CNT_W'(1);
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase

        if (w_busy) begin
            bus_enable = w_gen && !w_timeout;
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (IW'(i) == r_grant) begin
                    bus_addr  = m_addr[lane_lo(i, ADDR_W) +: ADDR_W];
                    bus_wdata = m_wdata[lane_lo(i, DATA_W) +: DATA_W];
                    bus_wstrb = m_wstrb[lane_lo(i, SW) +: SW];
                    bus_write = m_write[i];
                    m_rdata[lane_lo(i, DATA_W) +: DATA_W] = w_timeout ? DATA_W'(ERR_RDATA) : bus_rdata;
                    m_ready[i] = bus_ready || w_timeout;
                    m_err[i]   = w_timeout;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter_n.sv
// Self-checking bench for bus_rr_arbiter_n: directed scenarios with literal
// expectations, then randomized masters/bus checked every cycle against a
// behavioural model of the arbitration rules.
module tb_bus_rr_arbiter_n;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [N*SW-1:0]   m_wstrb;
    logic [N-1:0]      m_write, m_enable, m_lock;
    logic [N*DW-1:0]   m_rdata;
    logic [N-1:0]      m_ready, m_err;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic [SW-1:0]     bus_wstrb;
    logic              bus_write, bus_enable;
    logic [DW-1:0]     bus_rdata;
    logic              bus_ready;
    logic              grant_valid;
    logic [IW-1:0]     grant_id;

    bus_rr_arbiter_n #(
        .NUM_MASTERS    (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_write     (m_write),
        .m_enable    (m_enable),
        .m_lock      (m_lock),
        .m_rdata     (m_rdata),
        .m_ready     (m_ready),
        .m_err       (m_err),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_wstrb   (bus_wstrb),
        .bus_write   (bus_write),
        .bus_enable  (bus_enable),
        .bus_rdata   (bus_rdata),
        .bus_ready   (bus_ready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: who owns the bus, where round-robin resumes, how long
    // the current access has been waiting.
    bit        mb_busy  = 1'b0;
    int        mb_owner = 0;
    int        mb_ptr   = 0;
    int        mb_wait  = 0;
    logic [N-1:0] last_ready = '0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // First requester at or after start with wrap, skipping excl (-1 = none).
    function automatic int pick(input int start, input int excl);
        for (int k = 0; k < N; k++) begin
            if (m_enable[(start + k) % N] && ((start + k) % N) != excl) return (start + k) % N;
        end
        return -1;
    endfunction

    // Compare all DUT outputs against the model, shortly after the inputs settle.
    task automatic settle();
        logic          raw, to;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        logic [SW-1:0] es;
        logic          ewr, een;
        logic [N-1:0]  erdy, eerr;
        logic [N*DW-1:0] erd;
        #1;
        raw  = mb_busy && m_enable[mb_owner];
        to   = raw && (mb_wait == TO - 1) && !bus_ready;
        ea = '0; ew = '0; es = '0; ewr = 1'b0; een = 1'b0;
        erdy = '0; eerr = '0; erd = '0;
        if (mb_busy) begin
            ea   = m_addr[mb_owner*AW +: AW];
            ew   = m_wdata[mb_owner*DW +: DW];
            es   = m_wstrb[mb_owner*SW +: SW];
            ewr  = m_write[mb_owner];
            een  = raw && !to;
            erdy[mb_owner] = bus_ready || to;
            eerr[mb_owner] = to;
            erd[mb_owner*DW +: DW] = to ? '0 : bus_rdata;
        end
        chk("grant_valid", 256'(grant_valid), 256'(mb_busy));
        chk("grant_id",    256'(grant_id),    256'(mb_busy ? mb_owner : 0));
        chk("bus_addr",    256'(bus_addr),    256'(ea));
        chk("bus_wdata",   256'(bus_wdata),   256'(ew));
        chk("bus_wstrb",   256'(bus_wstrb),   256'(es));
        chk("bus_write",   256'(bus_write),   256'(ewr));
        chk("bus_enable",  256'(bus_enable),  256'(een));
        chk("m_ready",     256'(m_ready),     256'(erdy));
        chk("m_err",       256'(m_err),       256'(eerr));
        chk("m_rdata",     256'(m_rdata),     256'(erd));
        last_ready = erdy;
    endtask

    // Clock edge: advance the model by the arbitration rules, return at negedge.
    task automatic advance();
        logic raw, to, done;
        int   w;
        @(posedge clk);
        if (rst) begin
            mb_busy = 1'b0; mb_owner = 0; mb_ptr = 0; mb_wait = 0;
        end else if (!mb_busy) begin
            w = pick(mb_ptr, -1);
            if (w >= 0) begin
                mb_busy = 1'b1; mb_owner = w; mb_wait = 0;
            end
        end else begin
            raw  = m_enable[mb_owner];
            to   = raw && (mb_wait == TO - 1) && !bus_ready;
            done = raw && (bus_ready || to);
            if (done) begin
                mb_ptr  = (mb_owner + 1) % N;
                mb_wait = 0;
                if (!m_lock[mb_owner]) begin
                    w = pick((mb_owner + 1) % N, mb_owner);
                    if (w >= 0) mb_owner = w;
                    else        mb_busy  = 1'b0;
                end
            end else if (!raw && !m_lock[mb_owner]) begin
                mb_busy = 1'b0;
            end else if (raw && !bus_ready) begin
                mb_wait++;
            end
        end
        @(negedge clk);
    endtask

    task automatic load_req(input int i, input logic [AW-1:0] a);
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = $urandom;
        m_wstrb[i*SW +: SW] = SW'($urandom);
        m_write[i]          = 1'($urandom_range(0, 1));
        m_enable[i]         = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1; m_enable = '0; m_lock = '0; bus_ready = 1'b0;
        settle();
        advance();
        rst = 1'b0;
    endtask

    int t3_exp[6] = '{0, 1, 3, 0, 1, 3};
    int pct;
    logic raw_now;

    initial begin
        m_addr = '0; m_wdata = '0; m_wstrb = '0; m_write = '0;
        m_enable = '0; m_lock = '0; bus_rdata = '0; bus_ready = 1'b0;
        @(negedge clk);
        advance();
        rst = 1'b0;

        // Reset state
        settle();
        chk("rst_grant_valid", 256'(grant_valid), 256'(0));
        chk("rst_grant_id",    256'(grant_id),    256'(0));
        chk("rst_bus_enable",  256'(bus_enable),  256'(0));

        // Single master 2 read at 0x100
        for (int i = 0; i < N; i++) load_req(i, 32'h0);
        m_enable = '0;
        load_req(2, 32'h100);
        m_write[2] = 1'b0;
        settle();
        chk("t2_idle_ready", 256'(m_ready), 256'(0));
        advance();
        bus_ready = 1'b1; bus_rdata = 32'hCAFE0002;
        settle();
        chk("t2_gid",   256'(grant_id),   256'(2));
        chk("t2_addr",  256'(bus_addr),   256'(32'h100));
        chk("t2_ready", 256'(m_ready),    256'(4'b0100));
        chk("t2_rdata", 256'(m_rdata),    256'(128'h00000000_CAFE0002_00000000_00000000));
        advance();
        m_enable[2] = 1'b0; bus_ready = 1'b0;
        settle();
        chk("t2_back_idle", 256'(grant_valid), 256'(0));
        advance();

        // Masters 0,1,3 back to back with ready every cycle
        do_reset();
        m_enable = 4'b1011; bus_ready = 1'b1;
        settle();
        advance();
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("t3_gid",   256'(grant_id),    256'(t3_exp[k]));
            chk("t3_valid", 256'(grant_valid), 256'(1));
            advance();
        end
        m_enable = '0; bus_ready = 1'b0;
        settle();
        advance();

        // Lock hold on master 1 while master 0 waits
        do_reset();
        m_enable = 4'b0010; m_lock = 4'b0010;
        settle();
        advance();
        m_enable = 4'b0011; bus_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) m_lock[1] = 1'b0;
            settle();
            chk("t4_locked_gid", 256'(grant_id), 256'(1));
            advance();
        end
        settle();
        chk("t4_handoff_gid", 256'(grant_id), 256'(0));
        m_enable = '0; bus_ready = 1'b0;
        advance();

        // Timeout on master 2 with master 0 pending
        do_reset();
        m_enable = 4'b0100; bus_rdata = 32'h5555AAAA;
        settle();
        advance();
        m_enable = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t5_wait_en",    256'(bus_enable), 256'(1));
            chk("t5_wait_ready", 256'(m_ready),    256'(0));
            advance();
        end
        settle();
        chk("t5_to_ready", 256'(m_ready),    256'(4'b0100));
        chk("t5_to_err",   256'(m_err),      256'(4'b0100));
        chk("t5_to_rdata", 256'(m_rdata),    256'(0));
        chk("t5_to_en",    256'(bus_enable), 256'(0));
        advance();
        settle();
        chk("t5_next_gid", 256'(grant_id), 256'(0));
        chk("t5_next_err", 256'(m_err),    256'(0));
        m_enable = '0;
        advance();

        // Abandon: master 0 drops enable mid-wait
        do_reset();
        m_enable = 4'b0001;
        settle();
        advance();
        settle();
        advance();
        m_enable = 4'b0000;
        settle();
        chk("t6_bus_en", 256'(bus_enable), 256'(0));
        advance();
        m_enable = 4'b0011;
        settle();
        chk("t6_idle", 256'(grant_valid), 256'(0));
        advance();
        settle();
        chk("t6_ptr_kept_gid", 256'(grant_id), 256'(0));
        m_enable = '0;
        advance();

        // Reset while busy with master 3
        do_reset();
        m_enable = 4'b1000;
        settle();
        advance();
        settle();
        chk("t7_gid3", 256'(grant_id), 256'(3));
        advance();
        rst = 1'b1; m_enable = 4'b1010;
        settle();
        advance();
        rst = 1'b0;
        settle();
        chk("t7_rst_valid", 256'(grant_valid), 256'(0));
        chk("t7_rst_gid",   256'(grant_id),    256'(0));
        chk("t7_rst_en",    256'(bus_enable),  256'(0));
        advance();
        settle();
        chk("t7_first_gid", 256'(grant_id), 256'(1));
        m_enable = '0;
        advance();

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom_range(0, 499) == 0);
            pct = ((cyc / 500) % 2 == 1) ? 15 : 70;
            for (int i = 0; i < N; i++) begin
                if (last_ready[i])
                    m_enable[i] = 1'b0;
                else if (!m_enable[i] && $urandom_range(0, 2) == 0)
                    load_req(i, $urandom);
                else if (m_enable[i] && $urandom_range(0, 63) == 0)
                    m_enable[i] = 1'b0;
                if ($urandom_range(0, 7) == 0) m_lock[i] = ($urandom_range(0, 3) == 0);
            end
            raw_now   = mb_busy && m_enable[mb_owner];
            bus_ready = raw_now && ($urandom_range(0, 99) < pct);
            bus_rdata = $urandom;
            settle();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter_n.md
Name: bus_rr_arbiter_n

Overview:
- Registered-grant, N-master round-robin arbiter in front of the bus interconnect.
- Replaces the two-master arbiter when the cluster grows beyond two cores/ports.
- Adds a lock hold for atomic LR/SC/AMO sequences and a per-transaction timeout that completes a hung access with an error.
- Grant decisions are registered, so arbitration latency is one cycle. This breaks the combinational enable-to-bus path.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width (wstrb width = DATA_W/8)
- TIMEOUT_CYCLES, 256, cycles a granted access may wait for bus_ready; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_addr  in  NUM_MASTERS*ADDR_W  per-master address, lane i = bits [i*ADDR_W +: ADDR_W]
- m_wdata  in  NUM_MASTERS*DATA_W  per-master write data
- m_wstrb  in  NUM_MASTERS*DATA_W/8  per-master byte strobes
- m_write  in  NUM_MASTERS  per-master write flag
- m_enable  in  NUM_MASTERS  per-master request; held until that master's m_ready
- m_lock  in  NUM_MASTERS  keep grant after completion while high
- m_rdata  out  NUM_MASTERS*DATA_W  read data; only the granted lane is nonzero
- m_ready  out  NUM_MASTERS  completion strobe, one cycle
- m_err  out  NUM_MASTERS  timeout error, coincident with m_ready
- bus_addr / bus_wdata / bus_wstrb / bus_write / bus_enable  out  ADDR_W / DATA_W / DATA_W/8 / 1 / 1  downstream request
- bus_rdata  in  DATA_W  downstream read data
- bus_ready  in  1  downstream completion
- grant_valid  out  1  state is BUSY
- grant_id  out  clog2(NUM_MASTERS)  granted master index

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, grant_id=0, rr_ptr=0, wait_cnt=0.
  - All outputs are 0 while in IDLE; reset mid-transaction drops bus_enable on the next cycle.
- IDLE:
  - Bus outputs are 0.
  - If any m_enable is set, the winner is the first requester scanning from rr_ptr upward with wrap.
  - Next cycle: state=BUSY, grant_id=winner, wait_cnt=0.
- BUSY, bus forwarding:
  - Bus outputs mux lane grant_id; bus_enable = m_enable[grant_id].
  - m_rdata lane and m_ready[grant_id] pass bus_rdata/bus_ready through combinationally.
  - All other lanes are 0.
- BUSY, completion (bus_enable && bus_ready):
  - rr_ptr <= grant_id+1, with wrap.
  - If m_lock[grant_id]=1: stay BUSY on the same master, wait_cnt=0.
  - Else, if any other master has enable set: switch directly to the round-robin winner among others, scanning from grant_id+1. The current master is excluded because its enable is stale this cycle.
  - Else: go IDLE.
- BUSY, abandon:
  - m_enable[grant_id]=0, no ready and no lock: go IDLE with no rr_ptr change.
  - With lock and no enable: stay BUSY; wait_cnt is held.
- Timeout:
  - wait_cnt increments on each BUSY cycle with bus_enable && !bus_ready, saturating.
  - When wait_cnt == TIMEOUT_CYCLES-1 and bus_ready is still 0:
    - force bus_enable=0;
    - assert m_ready=1 and m_err=1 on the granted lane, with m_rdata=0;
    - treat it as a completion, lock rule included.
  - bus_ready in the same cycle wins: normal completion, no error.
- Width: m_err is only ever set together with m_ready.

Decomposition:
- Shared package bus_arb_pkg:
  - state encoding (IDLE=0, BUSY=1);
  - lane-slice helper;
  - ERR_RDATA=0;
  - clog2 function.
- One sub-module, rr_picker:
  - combinational rotate-priority encoder;
  - inputs: req vector, start pointer, exclude mask;
  - outputs: valid, index.
  - Instantiated twice: IDLE pick from rr_ptr, and handoff pick from grant_id+1 with the current master masked.

Test Plan:
- Single master 2 reads addr 0x100, bus_ready after 1 cycle → IDLE→BUSY in 1 cycle, m_ready[2] pulse, m_rdata lane2=bus_rdata, then IDLE.
- Masters 0, 1, 3 hold enable with ready every cycle → grant order 0,1,3,0,1,3 with no IDLE bubble between.
- Master 1 locked for 3 transactions while master 0 requests → grant stays 1 for all 3; master 0 granted on the completion after m_lock[1] drops.
- TIMEOUT_CYCLES=4, bus_ready held 0 → 4th wait cycle: m_ready=1, m_err=1, m_rdata=0, bus_enable=0; next master granted.
- Master 0 drops enable mid-wait → IDLE next cycle, rr_ptr unchanged, bus_enable=0.
- rst asserted while BUSY with master 3 → next cycle all outputs 0, grant_id=0; the first grant afterwards is the lowest-index requester.
